// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 2;
    localparam int FQ_CNT_W = $clog2(FQ_DEPTH + 1);

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One buffered response: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

    // Sequential PC successor; wraps at 2^32.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Latency: wires only.
// Backpressure: request side valid/ready; responses are unconditionally accepted in order.
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_queue.sv
// Small in-order FIFO buffering instruction responses while decode is stalled.
// Latency: pushed entry visible at head the cycle after the push.
// Backpressure: none internally; the caller's credit scheme keeps it from overflowing, clear wins over push.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  fq_entry_t           push_dat,
    input  logic                pop,
    input  logic                clear,
    output fq_entry_t           head,
    output logic [FQ_CNT_W-1:0] count,
    output logic                full,
    output logic                empty
);

    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

    fq_entry_t     mem [FQ_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FQ_CNT_W'(FQ_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Entry storage needs no reset: count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; clear empties the queue regardless of push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + FQ_CNT_W'(do_push) - FQ_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch: PC, imem request credit (2 in flight), response queue, IF/ID register; FETCH_PERF_CNT_EN builds perf counters.
// Latency: request accepted at N with k-cycle memory -> instr_D valid at N+k+1 when queue empty and no stall.
// Backpressure: stallF/imem_req_ready hold the PC; stallD holds IF/ID while up to 2 responses queue, then credit stops issue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            br_en_E,
    input  logic [XLEN-1:0] br_target_E,
    fetch_if.master         imem,
    output logic [XLEN-1:0] instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pc_plus4_D,
    output logic            valid_D,
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_redirect_cnt
);

    logic [XLEN-1:0]     pc_F;
    logic [XLEN-1:0]     rsp_pc;
    logic [1:0]          outstanding;
    logic [1:0]          discard;
    logic [2:0]          credit_used;
    logic                req_fire;
    logic                rsp_keep;
    logic                rsp_bypass;
    logic                ifid_load;

    fq_entry_t           q_head;
    fq_entry_t           q_push_dat;
    logic [FQ_CNT_W-1:0] q_count;
    logic                q_full;
    logic                q_empty;
    logic                q_push;
    logic                q_pop;

    logic [XLEN-1:0]     instr_n;
    logic [XLEN-1:0]     pc_n;
    logic [XLEN-1:0]     pc4_n;
    logic                valid_n;

    // In-flight requests plus buffered responses must leave room for every answer.
    assign credit_used         = {1'b0, outstanding} + 3'(q_count);
    assign imem.imem_req_valid = !rst && !br_en_E && !stallF && (credit_used < 3'd2);
    assign imem.imem_addr      = pc_F;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    // Wrong-path responses (still owed after a redirect, or arriving during one) are dropped.
    assign rsp_keep   = imem.imem_rsp_valid && (discard == 2'd0) && !br_en_E;
    assign rsp_bypass = rsp_keep && q_empty && !stallD && !flushD;
    assign q_push     = rsp_keep && !rsp_bypass;
    assign q_push_dat = '{instr: imem.imem_rsp_data, pc: rsp_pc};

    // flushD overrides stallD; a redirect leaves nothing correct-path to load.
    assign ifid_load = !stallD || flushD;
    assign q_pop     = ifid_load && !flushD && !br_en_E && !q_empty;

    fetch_queue u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (q_pop),
        .clear    (br_en_E),
        .head     (q_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    no_queue_overflow: assert property (@(posedge clk) disable iff (rst) !(q_push && q_full));

    // PC, outstanding-request count, discard count and response-PC tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_F        <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            outstanding <= outstanding + {1'b0, req_fire} - {1'b0, imem.imem_rsp_valid};
            if (br_en_E) begin
                pc_F    <= br_target_E;
                rsp_pc  <= br_target_E;
                // Everything still owed after this cycle belongs to the old path.
                discard <= outstanding - {1'b0, imem.imem_rsp_valid};
            end else begin
                if (req_fire) pc_F <= pc_next(pc_F);
                if (rsp_keep) rsp_pc <= pc_next(rsp_pc);
                if (imem.imem_rsp_valid && (discard != 2'd0)) discard <= discard - 2'd1;
            end
        end
    end

    // IF/ID next value: flush bubble, else queue head, else bypassed response, else bubble.
    always_comb begin
        instr_n = instr_D;
        pc_n    = pc_D;
        pc4_n   = pc_plus4_D;
        valid_n = valid_D;
        if (ifid_load) begin
            if (flushD) begin
                instr_n = NOP_INSTR;
                valid_n = 1'b0;
            end else if (q_pop) begin
                instr_n = q_head.instr;
                pc_n    = q_head.pc;
                pc4_n   = pc_next(q_head.pc);
                valid_n = 1'b1;
            end else if (rsp_bypass) begin
                instr_n = imem.imem_rsp_data;
                pc_n    = rsp_pc;
                pc4_n   = pc_next(rsp_pc);
                valid_n = 1'b1;
            end else begin
                instr_n = NOP_INSTR;
                valid_n = 1'b0;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_D    <= NOP_INSTR;
            pc_D       <= '0;
            pc_plus4_D <= 32'd4;
            valid_D    <= 1'b0;
        end else begin
            instr_D    <= instr_n;
            pc_D       <= pc_n;
            pc_plus4_D <= pc4_n;
            valid_D    <= valid_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        bubble_evt;
    logic [31:0] bubble_cnt_q;
    logic [31:0] redirect_cnt_q;

    // With stallD low IF/ID always loads, so an invalid next value is a bubble.
    assign bubble_evt = !stallD && !valid_n;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (bubble_evt) bubble_cnt_q   <= bubble_cnt_q + 32'd1;
            if (br_en_E)    redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign perf_bubble_cnt   = bubble_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`else
    assign perf_bubble_cnt   = '0;
    assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against an in-order imem model with programmable latency.
// Latency: memory answers k cycles after acceptance; instruction word is the bitwise inverse of its address.
// Backpressure: imem_req_ready driven per test; stallD/flushD/br_en_E driven directly.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        br_en_E = 1'b0;
    logic [31:0] br_target_E = '0;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc_plus4_D;
    logic        valid_D;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_redirect_cnt;

    fetch_if imem_bus();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk               (clk),
        .rst               (rst),
        .stallF            (stallF),
        .stallD            (stallD),
        .flushD            (flushD),
        .br_en_E           (br_en_E),
        .br_target_E       (br_target_E),
        .imem              (imem_bus),
        .instr_D           (instr_D),
        .pc_D              (pc_D),
        .pc_plus4_D        (pc_plus4_D),
        .valid_D           (valid_D),
        .perf_bubble_cnt   (perf_bubble_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Decode must hold a valid instruction fetched from pc.
    task automatic chk_d(input string tag, input logic [31:0] pc);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        chk({tag, "_valid"}, {31'd0, valid_D}, 32'd1);
        chk({tag, "_pc"}, pc_D, pc);
        chk({tag, "_instr"}, instr_D, ~pc);
        chk({tag, "_pc4"}, pc_plus4_D, p4);
    endtask

    // imem model: in-order, fixed latency per acceptance.
    int          mem_lat = 1;
    logic        mem_rdy = 1'b0;
    int          mem_cyc = 0;
    logic        mem_rsp_vld = 1'b0;
    logic [31:0] mem_rsp_dat = '0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    assign imem_bus.imem_req_ready = mem_rdy;
    assign imem_bus.imem_rsp_valid = mem_rsp_vld;
    assign imem_bus.imem_rsp_data  = mem_rsp_dat;

    always @(posedge clk) begin
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (mem_rsp_vld && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
                mq_addr.push_back(imem_bus.imem_addr);
                mq_due.push_back(mem_cyc + mem_lat);
            end
        end
        mem_cyc++;
        #1;
        if (!rst && mq_addr.size() > 0 && mq_due[0] <= mem_cyc) begin
            mem_rsp_vld = 1'b1;
            mem_rsp_dat = ~mq_addr[0];
        end else begin
            mem_rsp_vld = 1'b0;
            mem_rsp_dat = '0;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the caller at the start of cycle 0 (first cycle with rst low).
    task automatic do_reset();
        next_cyc();
        rst = 1'b1;
        stallD = 1'b0; flushD = 1'b0; br_en_E = 1'b0; mem_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_red;
        logic [31:0] exp_bub;

        // ---- reset state and steady streaming, k=1 ----
        do_reset();
        mem_lat = 1; mem_rdy = 1'b1;
        smp();                                                  // c0
        chk("rst_instr", instr_D, 32'h0000_0013);
        chk("rst_pc", pc_D, 32'h0);
        chk("rst_pc4", pc_plus4_D, 32'h4);
        chk("rst_valid", {31'd0, valid_D}, 32'd0);
        chk("c0_req_vld", {31'd0, imem_bus.imem_req_valid}, 32'd1);
        chk("c0_addr", imem_bus.imem_addr, 32'h100);
        next_cyc(); smp();                                      // c1
        chk("c1_addr", imem_bus.imem_addr, 32'h104);
        chk("c1_valid", {31'd0, valid_D}, 32'd0);
        for (int i = 0; i < 3; i++) begin                       // c2..c4
            next_cyc(); smp();
            chk_d("stream", 32'h100 + 32'(4 * i));
        end

        // ---- stallD for 3 cycles ----
        next_cyc(); stallD = 1'b1; smp();                       // c5
        chk_d("st5", 32'h10C);
        chk("st5_req", {31'd0, imem_bus.imem_req_valid}, 32'd1);
        next_cyc(); smp();                                      // c6
        chk_d("st6", 32'h10C);
        chk("st6_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        next_cyc(); smp();                                      // c7
        chk_d("st7", 32'h10C);
        chk("st7_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        next_cyc(); stallD = 1'b0; smp();                       // c8
        chk_d("st8", 32'h10C);
        chk("st8_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        next_cyc(); smp();                                      // c9
        chk_d("rel9", 32'h110);
        chk("rel9_addr", imem_bus.imem_addr, 32'h118);
        next_cyc(); smp(); chk_d("rel10", 32'h114);
        next_cyc(); smp(); chk_d("rel11", 32'h118);
        next_cyc(); smp(); chk_d("rel12", 32'h11C);

        // ---- redirect with 2 outstanding, k=3 ----
        do_reset();
        mem_lat = 3; mem_rdy = 1'b1;
        smp();                                                  // c0
        chk("br_c0_addr", imem_bus.imem_addr, 32'h100);
        next_cyc(); smp();                                      // c1
        chk("br_c1_addr", imem_bus.imem_addr, 32'h104);
        next_cyc(); br_en_E = 1'b1; br_target_E = 32'h200; smp(); // c2
        chk("br_c2_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        next_cyc(); br_en_E = 1'b0; smp();                      // c3
        chk("br_c3_addr", imem_bus.imem_addr, 32'h200);
        chk("br_c3_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        for (int i = 3; i < 8; i++) begin                       // c3..c7 (c3 already sampled)
            if (i > 3) begin
                next_cyc(); smp();
            end
            chk("br_stale_valid", {31'd0, valid_D}, 32'd0);
        end
        next_cyc(); smp();                                      // c8
        chk_d("br_tgt", 32'h200);

        // ---- flushD with stallD high ----
        stallD = 1'b1; flushD = 1'b1;                           // still c8
        next_cyc(); stallD = 1'b0; flushD = 1'b0; smp();        // c9
        chk("fl_instr", instr_D, 32'h0000_0013);
        chk("fl_valid", {31'd0, valid_D}, 32'd0);
        next_cyc(); smp();                                      // c10
        chk_d("fl_after", 32'h204);

        // ---- ready low 4 cycles, k=3, PC wrap ----
        do_reset();
        mem_lat = 3; mem_rdy = 1'b0;
        br_en_E = 1'b1; br_target_E = 32'hFFFF_FFF8; smp();     // c0
        chk("wr_c0_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        next_cyc(); br_en_E = 1'b0;
        for (int i = 1; i <= 4; i++) begin                      // c1..c4
            if (i > 1) next_cyc();
            smp();
            chk("wr_hold_addr", imem_bus.imem_addr, 32'hFFFF_FFF8);
        end
        chk("wr_hold_req", {31'd0, imem_bus.imem_req_valid}, 32'd1);
        next_cyc(); mem_rdy = 1'b1; smp();                      // c5
        chk("wr_c5_addr", imem_bus.imem_addr, 32'hFFFF_FFF8);
        next_cyc(); smp();                                      // c6
        chk("wr_c6_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        next_cyc(); smp();                                      // c7
        chk("wr_c7_addr", imem_bus.imem_addr, 32'h0);
        chk("wr_c7_req", {31'd0, imem_bus.imem_req_valid}, 32'd0);
        next_cyc(); next_cyc(); smp();                          // c9
        chk_d("wr9", 32'hFFFF_FFF8);
        next_cyc(); smp();                                      // c10
        chk_d("wr10", 32'hFFFF_FFFC);
        next_cyc(); smp();                                      // c11
        chk("wr11_valid", {31'd0, valid_D}, 32'd0);
        next_cyc(); next_cyc(); smp();                          // c13
        chk_d("wr13", 32'h0);
        next_cyc(); smp();                                      // c14
        chk_d("wr14", 32'h4);

        // ---- perf counters: 2 redirects, 5 bubble cycles ----
        do_reset();
        mem_rdy = 1'b0; stallD = 1'b1;
        br_en_E = 1'b1; br_target_E = 32'h300;                  // c0
        next_cyc();                                             // c1
        next_cyc(); br_en_E = 1'b0; stallD = 1'b0;              // c2..c6 unstalled
        repeat (4) next_cyc();
        next_cyc(); stallD = 1'b1; smp();                       // c7
`ifdef FETCH_PERF_CNT_EN
        exp_red = 32'd2;
        exp_bub = 32'd5;
`else
        exp_red = 32'd0;
        exp_bub = 32'd0;
`endif
        chk("perf_redirect", perf_redirect_cnt, exp_red);
        chk("perf_bubble", perf_bubble_cnt, exp_bub);
        chk("perf_valid", {31'd0, valid_D}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
